// File: rtl/conv_pool_stream_pkg.sv
// Shared constants, types and FSM encoding for the conv_pool_stream block.
//   frame_t  : 6x6x3 convolution result as an array of bytes
//   pooled_t : 3x3x3 pooled result as an array of bytes
package conv_pool_stream_pkg;

  localparam int unsigned N_CH     = 3;
  localparam int unsigned CONV_DIM = 6;
  localparam int unsigned POOL_DIM = 3;
  localparam int unsigned BYTE_W   = 8;

  localparam int unsigned N_CONV_B = N_CH * CONV_DIM * CONV_DIM;
  localparam int unsigned N_OUT    = N_CH * POOL_DIM * POOL_DIM;
  localparam int unsigned FRAME_W  = N_CONV_B * BYTE_W;
  localparam int unsigned POOL_W   = N_OUT * BYTE_W;
  localparam int unsigned IDX_W    = 5;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

  typedef logic [N_CONV_B-1:0][BYTE_W-1:0] frame_t;
  typedef logic [N_OUT-1:0][BYTE_W-1:0]    pooled_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POOL = 2'd1,
    SEND = 2'd2
  } state_e;

  // Byte index of convolution element (d,r,c) inside a frame.
  function automatic int unsigned conv_idx(input int unsigned d, input int unsigned r,
                                           input int unsigned c);
    return (d * CONV_DIM + r) * CONV_DIM + c;
  endfunction

endpackage

// File: rtl/conv_pool_stream_if.sv
// Frame-in / byte-out handshake bundle for conv_pool_stream.
//   in_valid/in_ready/conv_lin   : one-shot frame transfer
//   out_valid/out_ready/out_data/out_last : pooled byte stream
//   slave  : block side, master : producer/consumer side
interface conv_pool_stream_if;
  import conv_pool_stream_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [FRAME_W-1:0] conv_lin;
  logic               out_valid;
  logic               out_ready;
  logic [BYTE_W-1:0]  out_data;
  logic               out_last;

  modport slave (
    input  in_valid, conv_lin, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, conv_lin, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/max4_s8.sv
// Signed max of a 2x2 window of bytes, with optional clamp of negatives to 0.
//   x0..x3 : window bytes (two's complement)
//   y      : pooled byte
module max4_s8
  import conv_pool_stream_pkg::*;
#(
  parameter bit RELU = 1'b1
) (
  input  logic [BYTE_W-1:0] x0,
  input  logic [BYTE_W-1:0] x1,
  input  logic [BYTE_W-1:0] x2,
  input  logic [BYTE_W-1:0] x3,
  output logic [BYTE_W-1:0] y
);

  logic [BYTE_W-1:0] m01;
  logic [BYTE_W-1:0] m23;
  logic [BYTE_W-1:0] m;

  assign m01 = ($signed(x0) >= $signed(x1)) ? x0 : x1;
  assign m23 = ($signed(x2) >= $signed(x3)) ? x2 : x3;
  assign m   = ($signed(m01) >= $signed(m23)) ? m01 : m23;

  if (RELU) begin : g_relu
    assign y = m[BYTE_W-1] ? '0 : m;
  end else begin : g_pass
    assign y = m;
  end

endmodule

// File: rtl/conv_pool_stream.sv
// Captures one 6x6x3 conv frame, 2x2/stride-2 signed max-pools it to 3x3x3
// and streams the 27 bytes out channel-major.
//   clk, rst : clock, synchronous active-high reset
//   bus      : frame input and byte stream (slave side)
//   busy     : high whenever the FSM is not in IDLE
module conv_pool_stream
  import conv_pool_stream_pkg::*;
#(
  parameter bit RELU = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  conv_pool_stream_if.slave   bus,
  output logic                busy
);

  state_e            state_q, state_nx;
  logic [IDX_W-1:0]  idx_q, idx_nx;
  frame_t            frame_q;
  pooled_t           result_q;
  pooled_t           pooled_c;
  logic              frame_ld_c, result_ld_c;
  logic [BYTE_W-1:0] data_q, data_nx;
  logic              out_valid_q, out_last_q, in_ready_q, busy_q;

  // 27 parallel pooling windows over the captured frame.
  for (genvar gd = 0; gd < N_CH; gd++) begin : g_ch
    for (genvar gr = 0; gr < POOL_DIM; gr++) begin : g_row
      for (genvar gc = 0; gc < POOL_DIM; gc++) begin : g_col
        localparam int unsigned K  = (gd * POOL_DIM + gr) * POOL_DIM + gc;
        localparam int unsigned R0 = 2 * gr;
        localparam int unsigned C0 = 2 * gc;
        max4_s8 #(.RELU(RELU)) u_max4 (
          .x0 (frame_q[conv_idx(gd, R0,     C0)]),
          .x1 (frame_q[conv_idx(gd, R0,     C0 + 1)]),
          .x2 (frame_q[conv_idx(gd, R0 + 1, C0)]),
          .x3 (frame_q[conv_idx(gd, R0 + 1, C0 + 1)]),
          .y  (pooled_c[K])
        );
      end
    end
  end

  // Next state, index and next output byte.
  always_comb begin
    state_nx    = state_q;
    idx_nx      = idx_q;
    frame_ld_c  = 1'b0;
    result_ld_c = 1'b0;
    data_nx     = data_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_nx   = POOL;
          frame_ld_c = 1'b1;
        end
      end
      POOL: begin
        state_nx    = SEND;
        idx_nx      = '0;
        result_ld_c = 1'b1;
        data_nx     = pooled_c[0];
      end
      SEND: begin
        // out_valid is always high here, so out_ready alone completes a beat
        if (bus.out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_nx = IDLE;
          end else begin
            idx_nx  = idx_q + IDX_W'(1);
            data_nx = result_q[idx_nx];
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      frame_q     <= '0;
      result_q    <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_nx;
      idx_q       <= idx_nx;
      if (frame_ld_c)  frame_q  <= bus.conv_lin;
      if (result_ld_c) result_q <= pooled_c;
      data_q      <= data_nx;
      out_valid_q <= (state_nx == SEND);
      out_last_q  <= (state_nx == SEND) && (idx_nx == LAST_IDX);
      in_ready_q  <= (state_nx == IDLE);
      busy_q      <= (state_nx != IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_conv_pool_stream.sv
// Self-checking bench for conv_pool_stream: RELU=1 and RELU=0 instances share
// the same stimulus; accepted bytes are scored against a max-pool model.
module tb_conv_pool_stream;
  import conv_pool_stream_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, out_ready;
  logic [FRAME_W-1:0] conv_lin;
  logic busy0, busy1;

  always #5 clk = ~clk;

  conv_pool_stream_if bus0();
  conv_pool_stream_if bus1();

  assign bus0.in_valid  = in_valid;
  assign bus0.conv_lin  = conv_lin;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.conv_lin  = conv_lin;
  assign bus1.out_ready = out_ready;

  conv_pool_stream #(.RELU(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0), .busy(busy0));
  conv_pool_stream #(.RELU(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .busy(busy1));

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0] exp0_q[$];
  logic [8:0] exp1_q[$];

  function automatic int conv_at(input logic [FRAME_W-1:0] f, input int d, input int r,
                                 input int c);
    logic signed [7:0] b;
    b = f[(d*36 + r*6 + c)*8 +: 8];
    return int'(b);
  endfunction

  function automatic logic [7:0] ref_pool(input logic [FRAME_W-1:0] f, input int k,
                                          input bit relu);
    int d, pr, pc, m;
    d  = k / 9;
    pr = (k % 9) / 3;
    pc = k % 3;
    m  = -1000;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (conv_at(f, d, 2*pr + i, 2*pc + j) > m) m = conv_at(f, d, 2*pr + i, 2*pc + j);
    if (relu && m < 0) m = 0;
    return 8'(m);
  endfunction

  task automatic push_model(input logic [FRAME_W-1:0] f);
    for (int k = 0; k < 27; k++) begin
      exp0_q.push_back({k == 26, ref_pool(f, k, 1'b1)});
      exp1_q.push_back({k == 26, ref_pool(f, k, 1'b0)});
    end
  endtask

  function automatic logic [FRAME_W-1:0] ramp_frame();
    logic [FRAME_W-1:0] f;
    for (int d = 0; d < 3; d++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++)
          f[(d*36 + r*6 + c)*8 +: 8] = 8'(d*36 + r*6 + c);
    return f;
  endfunction

  function automatic logic [FRAME_W-1:0] rand_frame();
    logic [FRAME_W-1:0] f;
    for (int i = 0; i < 108; i++) f[i*8 +: 8] = 8'($urandom);
    return f;
  endfunction

  function automatic logic [FRAME_W-1:0] set_window(input logic [FRAME_W-1:0] fin,
      input int d, input int pr, input int pc, input logic [31:0] w);
    logic [FRAME_W-1:0] f;
    f = fin;
    f[(d*36 + (2*pr)*6   + 2*pc)*8     +: 8] = w[31:24];
    f[(d*36 + (2*pr)*6   + 2*pc + 1)*8 +: 8] = w[23:16];
    f[(d*36 + (2*pr+1)*6 + 2*pc)*8     +: 8] = w[15:8];
    f[(d*36 + (2*pr+1)*6 + 2*pc + 1)*8 +: 8] = w[7:0];
    return f;
  endfunction

  // ---------------- output monitor ----------------
  int byte_cnt, byte_cnt1, last_cnt, stall_cnt, total_last;
  logic [7:0] got0[27];
  logic [7:0] got1[27];
  logic       prev_stall;
  logic [7:0] prev_d0, prev_d1;
  logic       prev_l0;

  initial begin
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", bus0.out_valid, 1);
          check("stall_data", bus0.out_data, prev_d0);
          check("stall_last", bus0.out_last, prev_l0);
          check("stall_data_r0", bus1.out_data, prev_d1);
        end
        if (bus0.out_valid && out_ready) begin
          check("exp_avail_relu1", 32'(exp0_q.size() != 0), 1);
          if (exp0_q.size() != 0)
            check("byte_relu1", {bus0.out_last, bus0.out_data}, exp0_q.pop_front());
          if (byte_cnt < 27) got0[byte_cnt] = bus0.out_data;
          byte_cnt++;
          if (bus0.out_last) begin
            last_cnt++;
            total_last++;
          end
        end
        if (bus1.out_valid && out_ready) begin
          check("exp_avail_relu0", 32'(exp1_q.size() != 0), 1);
          if (exp1_q.size() != 0)
            check("byte_relu0", {bus1.out_last, bus1.out_data}, exp1_q.pop_front());
          if (byte_cnt1 < 27) got1[byte_cnt1] = bus1.out_data;
          byte_cnt1++;
        end
        prev_stall = bus0.out_valid && !out_ready;
        if (prev_stall) stall_cnt++;
        prev_d0 = bus0.out_data;
        prev_d1 = bus1.out_data;
        prev_l0 = bus0.out_last;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic ready_val(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return (n % 4 == 0) || (n % 4 == 3);
      default: return $urandom_range(0, 99) < 70;
    endcase
  endfunction

  // Hand over one frame and run until IDLE; n counts edges after the handshake.
  task automatic send_frame(input logic [FRAME_W-1:0] f, input int mode,
                            input bit hold_valid, output int n);
    check("in_ready_idle", bus0.in_ready, 1);
    push_model(f);
    byte_cnt = 0; byte_cnt1 = 0; last_cnt = 0; stall_cnt = 0;
    conv_lin = f;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("pool_busy_rdy_vld", {busy0, bus0.in_ready, bus0.out_valid}, 3'b100);
    if (!hold_valid) in_valid = 1'b0;
    conv_lin = rand_frame();
    n = 0;
    do begin
      out_ready = ready_val(mode, n);
      if (hold_valid) conv_lin = rand_frame();
      @(posedge clk); #1;
      n++;
      if (n == 1)  check("first_valid", bus0.out_valid, 1);
      if (n == 10) check("in_ready_busy", {bus0.in_ready, busy0}, 2'b01);
    end while (!bus0.in_ready && n < 400);
    check("frame_done", bus0.in_ready, 1);
    check("frame_cycles", n, 28 + stall_cnt);
    check("byte_count", byte_cnt, 27);
    check("last_count", last_cnt, 1);
    check("drained_relu1", exp0_q.size(), 0);
    check("drained_relu0", exp1_q.size(), 0);
  endtask

  initial begin
    logic [FRAME_W-1:0] f;
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; conv_lin = '0;
    total_last = 0; byte_cnt = 0; byte_cnt1 = 0; last_cnt = 0; stall_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {bus0.in_ready, bus0.out_valid, bus0.out_last, busy0}, 4'b1000);
    check("rst_data", bus0.out_data, 0);
    check("rst_state_r0", {bus1.in_ready, bus1.out_valid, busy1}, 3'b100);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst", {bus0.in_ready, bus0.out_valid}, 2'b10);

    // Ramp frame, free-running sink.
    send_frame(ramp_frame(), 0, 1'b0, n);
    check("ramp_b0", got0[0], 7);
    check("ramp_b1", got0[1], 9);
    check("ramp_b2", got0[2], 11);
    check("ramp_b26", got0[26], 107);
    check("ramp_period", n, 28);

    // Same frame under 1,0,0,1 back-pressure.
    send_frame(ramp_frame(), 1, 1'b0, n);
    check("bp_b26", got0[26], 107);
    check("bp_stalls_seen", 32'(stall_cnt > 0), 1);

    // Signed-compare windows.
    f = set_window(rand_frame(), 0, 0, 0, 32'h80FF7F00);
    f = set_window(f, 1, 1, 2, {8'hFB, 8'hFD, 8'h80, 8'hF9});
    send_frame(f, 0, 1'b0, n);
    check("win_max_relu1", got0[0], 8'h7F);
    check("win_max_relu0", got1[0], 8'h7F);
    check("win_neg_relu1", got0[14], 8'h00);
    check("win_neg_relu0", got1[14], 8'hFD);

    // in_valid held high with changing data during SEND; next frame at T+29.
    send_frame(rand_frame(), 0, 1'b1, n);
    check("accept_period", n, 28);
    send_frame(rand_frame(), 0, 1'b0, n);

    // Reset after byte 10 drops the frame.
    push_model(rand_frame());
    conv_lin = rand_frame();
    exp0_q.delete(); exp1_q.delete();
    f = rand_frame();
    push_model(f);
    byte_cnt = 0; byte_cnt1 = 0;
    conv_lin = f; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (byte_cnt < 11 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_byte10", byte_cnt, 11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp0_q.delete(); exp1_q.delete();
    check("mid_rst_ctrl", {bus0.out_valid, bus0.in_ready, busy0}, 3'b010);
    check("mid_rst_data", bus0.out_data, 0);
    check("mid_rst_ctrl_r0", {bus1.out_valid, bus1.in_ready, busy1}, 3'b010);
    repeat (3) begin
      @(posedge clk); #1;
      check("no_partial", bus0.out_valid, 0);
    end
    send_frame(rand_frame(), 0, 1'b0, n);

    // Three back-to-back random frames, random sink.
    total_last = 0;
    for (int i = 0; i < 3; i++) send_frame(rand_frame(), 2, 1'b0, n);
    check("b2b_lasts", total_last, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
